// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its MDU sequencer.
package hazard_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned FWD_W     = 2;
    localparam int unsigned MDU_CNT_W = 4;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_t;

    // $zero is hardwired, so it never creates a dependency
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Sequences a multi-cycle mult/div in execute and pulses the HI/LO commit on its last cycle.
module mdu_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o,
    output logic hilo_write_o,
    output logic block_o
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_CYCLES - 2);
    // A two-cycle op has no intermediate BUSY cycle
    localparam mdu_state_t START_STATE = (MDU_CYCLES == 2) ? MDU_DONE : MDU_BUSY;

    mdu_state_t             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a start while BUSY is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MDU_IDLE, MDU_DONE: begin
                if (start_i) begin
                    state_d = START_STATE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - MDU_CNT_W'(1);
                if (cnt_q <= MDU_CNT_W'(1)) begin
                    state_d = MDU_DONE;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy_o       = (state_q != MDU_IDLE);
        hilo_write_o = (state_q == MDU_DONE);
        block_o      = (state_q == MDU_BUSY) | (start_i & rst_n & (state_q != MDU_BUSY));
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage MIPS hazard unit: operand forwarding, load/branch/MDU stalls, flushes and a stall counter.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REG_W-1:0]   RsD,
    input  logic [REG_W-1:0]   RtD,
    input  logic [REG_W-1:0]   RsE,
    input  logic [REG_W-1:0]   RtE,
    input  logic [REG_W-1:0]   WriteRegE,
    input  logic [REG_W-1:0]   WriteRegM,
    input  logic [REG_W-1:0]   WriteRegW,
    input  logic               RegWriteE,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               MemtoRegE,
    input  logic               MemtoRegM,
    input  logic               BranchD,
    input  logic               JumpD,
    input  logic               PCSrcD,
    input  logic               MdStartD,
    input  logic               MdStartE,
    input  logic               HiLoReadD,
    output logic [FWD_W-1:0]   ForwardAE,
    output logic [FWD_W-1:0]   ForwardBE,
    output logic               ForwardAD,
    output logic               ForwardBD,
    output logic               StallF,
    output logic               StallD,
    output logic               FlushD,
    output logic               FlushE,
    output logic               MduBusy,
    output logic               HiLoWrite,
    output logic [CNT_W-1:0]   StallCount
);

    logic             md_block;
    logic             lw_stall;
    logic             br_stall;
    logic             md_stall;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mdu_sequencer #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (MdStartE),
        .busy_o       (MduBusy),
        .hilo_write_o (HiLoWrite),
        .block_o      (md_block)
    );

    // Execute operand forwarding, memory stage has priority over writeback
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RegWriteM && reg_match(WriteRegM, RsE)) begin
            ForwardAE = FWD_MEM;
        end else if (RegWriteW && reg_match(WriteRegW, RsE)) begin
            ForwardAE = FWD_WB;
        end
        if (RegWriteM && reg_match(WriteRegM, RtE)) begin
            ForwardBE = FWD_MEM;
        end else if (RegWriteW && reg_match(WriteRegW, RtE)) begin
            ForwardBE = FWD_WB;
        end
        ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
        ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);
    end

    // Stall and flush decode; a stall suppresses the branch/jump flush of decode
    always_comb begin
        lw_stall = MemtoRegE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));
        br_stall = BranchD &&
                   ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                    (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
        md_stall = (MdStartD || HiLoReadD) && md_block;
        stall    = lw_stall || br_stall || md_stall;
        StallF   = stall;
        StallD   = stall;
        FlushE   = stall;
        FlushD   = (PCSrcD || JumpD) && !stall;
    end

    // Saturating stall performance counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table for the combinational decode, cycle sequences for the MDU and counter.
module tb_hazard_controller;

    localparam int unsigned MDU_CYCLES = 4;
    localparam int unsigned CNT_W      = 16;

    logic             clk;
    logic             rst_n;
    logic [4:0]       RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic             BranchD, JumpD, PCSrcD, MdStartD, MdStartE, HiLoReadD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE;
    logic             MduBusy, HiLoWrite;
    logic [CNT_W-1:0] StallCount;

    hazard_controller #(
        .MDU_CYCLES (MDU_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RsD        (RsD),
        .RtD        (RtD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemtoRegE  (MemtoRegE),
        .MemtoRegM  (MemtoRegM),
        .BranchD    (BranchD),
        .JumpD      (JumpD),
        .PCSrcD     (PCSrcD),
        .MdStartD   (MdStartD),
        .MdStartE   (MdStartE),
        .HiLoReadD  (HiLoReadD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .MduBusy    (MduBusy),
        .HiLoWrite  (HiLoWrite),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
        logic       rwe, rwm, rww, mre, mrm, br, jp, pcs;
        logic [1:0] fae, fbe;
        logic       fad, fbd, stall, flushd;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs [16];
    sb_t  sb_q [$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.tag, act, e.exp);
            end
        end
    endtask

    task automatic clear_inputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0;
        BranchD = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0;
        MdStartD = 1'b0; MdStartE = 1'b0; HiLoReadD = 1'b0;
    endtask

    function automatic logic [31:0] mdu_obs();
        return 32'({MduBusy, HiLoWrite, StallD});
    endfunction

    // One clock of MDU stimulus with expected {MduBusy, HiLoWrite, StallD}
    task automatic mdu_cycle(input logic start, input logic mdd, input logic hrd,
                             input logic eb, input logic eh, input logic es, input string tag);
        @(posedge clk); #1;
        MdStartE  = start;
        MdStartD  = mdd;
        HiLoReadD = hrd;
        push(tag, 32'({eb, eh, es}));
        push({tag, "_cnt"}, 32'(exp_cnt));
        @(negedge clk);
        check_pop(mdu_obs());
        check_pop(32'(StallCount));
        if (es) exp_cnt++;
    endtask

    // A new mult/div must never reach execute while the unit is mid-operation
    always @(negedge clk) begin
        if (rst_n && MdStartE && MduBusy && !HiLoWrite)
            $error("MdStartE asserted while MDU busy");
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //          rsd    rtd    rse    rte    wre    wrm    wrw   rwe  rwm  rww  mre  mrm  br   jp   pcs  fae    fbe    fad  fbd  stl  fld
        vecs[0]  = '{5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd8, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0, 5'd3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b0,1'b0,1'b0,1'b0};
        vecs[4]  = '{5'd0, 5'd0, 5'd7, 5'd6, 5'd0, 5'd6, 5'd7, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{5'd12,5'd13,5'd0, 5'd0, 5'd0, 5'd12,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0};
        vecs[10] = '{5'd6, 5'd7, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1};
        vecs[11] = '{5'd0, 5'd11,5'd0, 5'd0, 5'd0, 5'd11,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1};
        vecs[13] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
        vecs[14] = '{5'd10,5'd0, 5'd0, 5'd0, 5'd0, 5'd10,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b1,1'b0,1'b0,1'b1};
        vecs[15] = '{5'd9, 5'd0, 5'd2, 5'd0, 5'd9, 5'd0, 5'd2, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b1,1'b0};

        rst_n = 1'b0;
        clear_inputs();

        // Reset: MDU requests must not stall, load-use decode still does, counter stays 0
        @(posedge clk); #1;
        MdStartE = 1'b1; MdStartD = 1'b1; HiLoReadD = 1'b1;
        push("rst_mdstall", 32'h0);
        push("rst_cnt0", 32'h0);
        @(negedge clk);
        check_pop(mdu_obs());
        check_pop(32'(StallCount));

        @(posedge clk); #1;
        clear_inputs();
        MemtoRegE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        push("rst_lwstall", 32'h1);
        @(negedge clk);
        check_pop(mdu_obs());

        @(posedge clk); #1;
        clear_inputs();
        push("rst_cnt_hold", 32'h0);
        @(negedge clk);
        check_pop(32'(StallCount));
        rst_n = 1'b1;
        exp_cnt = 0;

        // Combinational decode table
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            RsD = vecs[i].rsd; RtD = vecs[i].rtd; RsE = vecs[i].rse; RtE = vecs[i].rte;
            WriteRegE = vecs[i].wre; WriteRegM = vecs[i].wrm; WriteRegW = vecs[i].wrw;
            RegWriteE = vecs[i].rwe; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemtoRegE = vecs[i].mre; MemtoRegM = vecs[i].mrm;
            BranchD = vecs[i].br; JumpD = vecs[i].jp; PCSrcD = vecs[i].pcs;
            push($sformatf("vec%0d", i), 32'({vecs[i].fae, vecs[i].fbe, vecs[i].fad, vecs[i].fbd,
                                             vecs[i].stall, vecs[i].stall, vecs[i].flushd, vecs[i].stall}));
            push($sformatf("vec%0d_cnt", i), 32'(exp_cnt));
            @(negedge clk);
            check_pop(32'({ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE}));
            check_pop(32'(StallCount));
            if (vecs[i].stall) exp_cnt++;
        end

        @(posedge clk); #1;
        clear_inputs();

        // Single op with mfhi held in decode
        mdu_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "mdu_c0");
        mdu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "mdu_c1");
        mdu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "mdu_c2");
        mdu_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "mdu_c3");
        mdu_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mdu_c4");

        // Back-to-back ops, second started in the DONE cycle
        mdu_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_c0");
        mdu_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "b2b_c1");
        mdu_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "b2b_c2");
        mdu_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "b2b_c3");
        mdu_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "b2b_c4");
        mdu_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "b2b_c5");
        mdu_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "b2b_c6");
        mdu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_c7");

        // Reset while BUSY aborts the op without a commit pulse
        mdu_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_c0");
        mdu_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "abort_c1");
        @(posedge clk); #1;
        clear_inputs();
        #1 rst_n = 1'b0;
        exp_cnt = 0;
        push("abort_rst", 32'h0);
        push("abort_rst_cnt", 32'h0);
        @(negedge clk);
        check_pop(mdu_obs());
        check_pop(32'(StallCount));
        @(posedge clk); #1;
        push("abort_hold", 32'h0);
        @(negedge clk);
        check_pop(mdu_obs());
        #1 rst_n = 1'b1;
        mdu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_c4");
        mdu_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_c5");

        // Counter saturation under a continuous load-use stall
        @(posedge clk); #1;
        MemtoRegE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        repeat ((1 << CNT_W) - 1) @(posedge clk);
        push("sat_reach", 32'(CNT_W'('1)));
        @(negedge clk);
        check_pop(32'(StallCount));
        repeat (6) @(posedge clk);
        push("sat_hold", 32'(CNT_W'('1)));
        @(negedge clk);
        check_pop(32'(StallCount));
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        push("sat_idle", 32'(CNT_W'('1)));
        push("sat_idle_stall", 32'h0);
        @(negedge clk);
        check_pop(32'(StallCount));
        check_pop(32'(StallD));

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the five-stage MIPS core. Drives the execute-stage operand forwarding selects and the fetch/decode stall and flush controls. Sequences the multi-cycle multiply/divide unit (MDU) that shares the execute stage, holding decode until HI/LO results are ready. Forwarding and stall decode are combinational from pipeline state; the MDU sequencer and the stall performance counter are registered.

## Interface
- `MDU_CYCLES`, 4: execute cycles a mult/div occupies, including the start cycle; legal range 2..16.
- `CNT_W`, 16: width of the stall performance counter.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RsD`, `RtD`  in  5 each  decode-stage source registers.
- `RsE`, `RtE`  in  5 each  execute-stage source registers.
- `WriteRegE`, `WriteRegM`, `WriteRegW`  in  5 each  destination register per stage.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1 each  destination write enable per stage.
- `MemtoRegE`, `MemtoRegM`  in  1 each  the stage holds a load.
- `BranchD`, `JumpD`, `PCSrcD`  in  1 each  decode branch, jump, and branch-taken.
- `MdStartD`, `MdStartE`  in  1 each  mult/div instruction in decode / in execute.
- `HiLoReadD`  in  1  mfhi/mflo in decode.
- `ForwardAE`, `ForwardBE`  out  2 each  operand select: 00 register file, 01 writeback result, 10 `ALUOutM`, 11 reserved (never driven).
- `ForwardAD`, `ForwardBD`  out  1 each  forward `ALUOutM` to the decode branch comparator.
- `StallF`, `StallD`  out  1 each  hold the PC and the IF/ID register.
- `FlushD`, `FlushE`  out  1 each  clear the IF/ID and ID/EX registers (insert a bubble).
- `MduBusy`  out  1  MDU sequencer is not IDLE.
- `HiLoWrite`  out  1  one-cycle pulse that commits the MDU result to HI/LO.
- `StallCount`  out  `CNT_W`  saturating count of cycles with `StallD`=1.

## Operation
- Register 0 never matches any hazard check.
- ForwardAE: 10 if `RegWriteM` and `WriteRegM`==`RsE`; else 01 if `RegWriteW` and `WriteRegW`==`RsE`; else 00. The M stage has priority over W. ForwardBE uses the same rule with `RtE`.
- ForwardAD/BD: 1 when `RegWriteM` and `WriteRegM` equals `RsD`/`RtD`.
- lwstall: `MemtoRegE` and `WriteRegE` equals `RsD` or `RtD`.
- brstall: `BranchD` and either:
  - `RegWriteE` and `WriteRegE` equals `RsD`/`RtD`, or
  - `MemtoRegM` and `WriteRegM` equals `RsD`/`RtD`.
- mdstall: (`MdStartD` or `HiLoReadD`) while the state is BUSY, or while `MdStartE` is accepted this cycle.
- `StallF` = `StallD` = `FlushE` = lwstall | brstall | mdstall.
- `FlushD` = (`PCSrcD` | `JumpD`) & ~`StallD`.
- MDU sequencer states: IDLE, BUSY, DONE. Down-counter `cnt` is 4 bits.
  - IDLE → BUSY on `MdStartE`; `cnt` loads `MDU_CYCLES`-2.
  - BUSY: `cnt` decrements each cycle; at `cnt`==0 the state goes to DONE.
  - DONE: `HiLoWrite`=1 for exactly this cycle. Goes to BUSY if `MdStartE`=1 (reload `cnt`), otherwise to IDLE.
  - `MdStartE` while in BUSY is a protocol violation. It cannot occur because decode is stalled; it is ignored and flagged by a bench assertion.
- `MduBusy` = state != IDLE.
- `StallCount` increments on every cycle with `StallD`=1 and holds at all-ones.

## Timing
- Reset (async assert, sync to `clk` on deassert):
  - state IDLE, `cnt` 0, `StallCount` 0.
  - `HiLoWrite` 0, `MduBusy` 0.
  - Combinational outputs follow their inputs, with mdstall forced 0.
- Forwarding, stall and flush outputs are combinational. They are valid in the same cycle as their inputs; no added latency.
- MDU: with start accepted at edge N (`MdStartE` high during cycle N), `HiLoWrite` is high during cycle N+`MDU_CYCLES`-1.
- A `HiLoReadD` in that DONE cycle is not stalled; HI/LO write-through is handled by the register.
- Reset asserted mid-operation aborts the MDU op; no `HiLoWrite` pulse is produced.
- When stall and branch-taken occur in the same cycle, stall wins: `FlushD`=0 and `FlushE`=1.

## Structure
- Shared package `hazard_pkg`:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - MDU state enum `mdu_state_t`.
- One sub-module, `mdu_sequencer`, contains the FSM, `cnt` and `HiLoWrite`. The top level holds the forwarding/stall logic and `StallCount`.

## Test plan
- `RegWriteM`=1, `WriteRegM`=8, `RsE`=8; `RegWriteW`=1, `WriteRegW`=8 → `ForwardAE`=10. With `RsE`=0 under the same setup → `ForwardAE`=00.
- `MemtoRegE`=1, `WriteRegE`=9, `RtD`=9 → `StallF`=`StallD`=`FlushE`=1 for one cycle; `StallCount` goes 0→1.
- `BranchD`=1, `RegWriteE`=1, `WriteRegE`=RsD=5, `PCSrcD`=1 → stall asserted, `FlushD`=0.
- Same branch with no hazard → `FlushD`=1, no stall.
- `MDU_CYCLES`=4, `MdStartE` pulse at cycle 0 → `MduBusy` high cycles 1–3, `HiLoWrite` only in cycle 3. `HiLoReadD` held is stalled in cycles 0–2 and released in cycle 3.
- Back-to-back: `MdStartE` in the DONE cycle → returns to BUSY and a second `HiLoWrite` appears 3 cycles later.
- `rst_n` dropped while BUSY → outputs reset immediately, no `HiLoWrite`. Hold stall for 2^CNT_W+5 cycles → `StallCount` saturates at all-ones.
